muldiv_unit: RTL

//  Iterative RV32M multiply/divide execute unit, parametrised in operand width and destination-tag width.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes. Results carry their rd tag.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] rd_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TAG_W-1:0]   rd_q;
    logic               sel_hi_q;   // multiply returns upper product half
    logic               sel_rem_q;  // divide returns remainder
    logic               neg_res_q;  // negate product / quotient
    logic               neg_rem_q;  // negate remainder (dividend sign)
    logic [XLEN-1:0]    opnd_q;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]  acc_q;      // MUL: {partial, multiplier}; DIV: {rem, quo}

    logic              signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] mul_next, prod;
    logic [XLEN:0]     shifted, diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo_s, rem_s, mul_res, div_res;
    logic              last;

    // Operand decode, magnitudes and divide special cases at accept
    always_comb begin
        signed_a    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        signed_b    = op[2] ? ~op[0] : ~op[1];
        neg_a       = signed_a & a[XLEN-1];
        neg_b       = signed_b & b[XLEN-1];
        mag_a       = neg_a ? -a : a;
        mag_b       = neg_b ? -b : b;
        div_zero    = (b == '0);
        div_ovf     = ~op[0] & (a == MinNeg) & (b == '1);
        special     = op[2] & (div_zero | div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? a : '1;
        end else begin
            special_res = op[1] ? '0 : a;
        end
    end

    // One iteration step of each datapath plus final sign fix-up
    always_comb begin
        mul_add  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_add, acc_q[XLEN-1:1]};
        prod     = neg_res_q ? -mul_next : mul_next;
        mul_res  = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

        shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = shifted - {1'b0, opnd_q};
        // No borrow means the shifted remainder reached the divisor
        if (!diff[XLEN]) begin
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        quo_s    = neg_res_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        rem_s    = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        div_res  = sel_rem_q ? rem_s : quo_s;

        last     = (cnt_q == CNT_W'(XLEN - 1));
    end

    // Control FSM with registered outputs and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rd_q      <= '0;
            sel_hi_q  <= 1'b0;
            sel_rem_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (special) begin
                                done   <= 1'b1;
                                result <= special_res;
                                rd_out <= rd_in;
                            end else begin
                                state_q   <= op[2] ? StDiv : StMul;
                                busy      <= 1'b1;
                                cnt_q     <= '0;
                                rd_q      <= rd_in;
                                sel_hi_q  <= (op[1:0] != 2'b00);
                                sel_rem_q <= op[1];
                                neg_res_q <= neg_a ^ neg_b;
                                neg_rem_q <= neg_a;
                                opnd_q    <= op[2] ? mag_b : mag_a;
                                acc_q     <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                            end
                        end
                    end
                    StMul: begin
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= mul_res;
                            rd_out  <= rd_q;
                        end
                    end
                    StDiv: begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= div_res;
                            rd_out  <= rd_q;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
